// File: rtl/dmem_bus_adapter_if.sv
// rtl/dmem_bus_adapter_if.sv - data-memory bus signal bundle between the adapter and the memory slave
interface dmem_bus_adapter_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [29:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        input  dat_i, ack_i, err_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        output dat_i, ack_i, err_i
    );
endinterface

// File: rtl/dmem_bus_adapter.sv
// rtl/dmem_bus_adapter.sv - single-outstanding load/store adapter from the core EX stage to the data bus
module dmem_bus_adapter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wmask_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        err_o,
    dmem_bus_adapter_if.master bus
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [29:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;
    logic        fault;

    // Byte offset is already folded into the lane-shifted data and mask.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^addr_i[1:0];

    assign cnt_inc = cnt_q + 8'd1;
    // A cycle without ack that would push the counter to the limit counts as a bus error.
    assign fault   = bus.err_i || (!bus.ack_i && (cnt_inc == TIMEOUT_CYCLES));

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    adr_d   = addr_i[31:2];
                    dat_d   = wdata_i;
                    mask_d  = wmask_i;
                    cnt_d   = 8'd0;
                    cyc_d   = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (fault) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = 32'd0;
                    end
                end else if (bus.ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = bus.dat_i;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 30'd0;
            dat_q   <= 32'd0;
            mask_q  <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        case (state_q)
            IDLE:    stall_o = req_i;
            BUS:     stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    assign bus.cyc_o = cyc_q;
    assign bus.stb_o = cyc_q;
    assign bus.we_o  = we_q;
    assign bus.adr_o = adr_q;
    assign bus.dat_o = dat_q;
    assign bus.sel_o = we_q ? mask_q : 4'hF;

endmodule

// File: tb/tb_dmem_bus_adapter.sv
// tb/tb_dmem_bus_adapter.sv - randomized transaction-level bench for dmem_bus_adapter
module tb_dmem_bus_adapter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  wmask_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rdata_exp = 32'd0;

    dmem_bus_adapter_if bus_if();

    dmem_bus_adapter #(.TIMEOUT_CYCLES(8'(TMO))) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .wmask_i (wmask_i),
        .rdata_o (rdata_o),
        .stall_o (stall_o),
        .err_o   (err_o),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge with the FSM idle; returns just after the
    // falling edge of the following idle cycle. waits < 0 means the slave never answers.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input logic [31:0] rd, input int waits,
                          input bit with_err, input bit also_ack, input bit keep_req);
        int nbus;
        int exp_n;
        bit exp_err;
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wdata;
        wmask_i = mask;
        #1;
        check_val("idle_stall", 32'(stall_o), 32'd1);
        exp_n   = (waits < 0) ? TMO : waits + 1;
        exp_err = (waits < 0) || with_err;
        nbus    = 0;
        @(posedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!bus_if.cyc_o) break;
            nbus++;
            check_val("bus_stall", 32'(stall_o), 32'd1);
            check_val("bus_stb", 32'(bus_if.stb_o), 32'd1);
            if (nbus == 1) begin
                check_val("bus_adr", 32'(bus_if.adr_o), 32'(addr[31:2]));
                check_val("bus_we", 32'(bus_if.we_o), 32'(we));
                check_val("bus_sel", 32'(bus_if.sel_o), we ? 32'(mask) : 32'hF);
                check_val("bus_dat", bus_if.dat_o, wdata);
            end
            bus_if.ack_i = 1'b0;
            bus_if.err_i = 1'b0;
            bus_if.dat_i = $urandom;
            if (waits >= 0 && nbus == waits + 1) begin
                bus_if.dat_i = rd;
                if (with_err) begin
                    bus_if.err_i = 1'b1;
                    bus_if.ack_i = also_ack;
                end else begin
                    bus_if.ack_i = 1'b1;
                end
            end
        end
        check_val("bus_cycles", 32'(nbus), 32'(exp_n));
        if (!we) rdata_exp = exp_err ? 32'd0 : rd;
        check_val("done_err", 32'(err_o), 32'(exp_err));
        check_val("done_stall", 32'(stall_o), 32'd0);
        check_val("done_rdata", rdata_o, rdata_exp);
        // Responses outside an access must be ignored.
        bus_if.ack_i = 1'($urandom);
        bus_if.err_i = 1'($urandom);
        bus_if.dat_i = $urandom;
        if (!keep_req) req_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus_if.ack_i = 1'b0;
        bus_if.err_i = 1'b0;
        check_val("idle_cyc", 32'(bus_if.cyc_o), 32'd0);
        check_val("idle_err", 32'(err_o), 32'd0);
        check_val("idle_rdata", rdata_o, rdata_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i      = 1'b1;
        req_i        = 1'b0;
        we_i         = 1'b0;
        addr_i       = 32'd0;
        wdata_i      = 32'd0;
        wmask_i      = 4'd0;
        bus_if.ack_i = 1'b0;
        bus_if.err_i = 1'b0;
        bus_if.dat_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_cyc", 32'(bus_if.cyc_o), 32'd0);
        check_val("rst_stb", 32'(bus_if.stb_o), 32'd0);
        check_val("rst_we", 32'(bus_if.we_o), 32'd0);
        check_val("rst_err", 32'(err_o), 32'd0);
        check_val("rst_adr", 32'(bus_if.adr_o), 32'd0);
        check_val("rst_dat", bus_if.dat_o, 32'd0);
        check_val("rst_rdata", rdata_o, 32'd0);
        check_val("rst_stall", 32'(stall_o), 32'd0);
        reset_i = 1'b0;

        // Zero-wait load, store with 3 waits, error+ack, timeout, misaligned pair
        do_txn(1'b0, 32'h0000_1004, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1'b0, 1'b0, 1'b0);
        do_txn(1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010, 32'h5555_5555, 3, 1'b0, 1'b0, 1'b0);
        do_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 1'b1, 1'b1, 1'b0);
        do_txn(1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h1234_5678, 1, 1'b0, 1'b0, 1'b0);
        do_txn(1'b0, 32'h0000_0044, 32'h0, 4'h0, 32'h0, -1, 1'b0, 1'b0, 1'b0);
        do_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hAAAA_0001, 0, 1'b0, 1'b0, 1'b1);
        do_txn(1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'hBBBB_0002, 0, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            int mode;
            int waits;
            bit with_err;
            bit keep;
            mode     = int'($urandom_range(0, 5));
            with_err = (mode == 4);
            waits    = (mode == 5) ? -1 : (mode == 4 ? int'($urandom_range(0, 3)) : mode);
            keep     = 1'($urandom);
            do_txn(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom),
                   $urandom, waits, with_err, 1'($urandom), keep);
            if (!keep) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    bus_if.ack_i = 1'($urandom);
                    bus_if.err_i = 1'($urandom);
                    @(posedge clk);
                    @(negedge clk);
                    bus_if.ack_i = 1'b0;
                    bus_if.err_i = 1'b0;
                    check_val("gap_cyc", 32'(bus_if.cyc_o), 32'd0);
                    check_val("gap_stall", 32'(stall_o), 32'd0);
                    check_val("gap_rdata", rdata_o, rdata_exp);
                end
            end
        end

        // Reset during a wait aborts the access; a late ack must not land
        req_i   = 1'b1;
        we_i    = 1'b0;
        addr_i  = 32'h0000_0300;
        @(posedge clk);
        @(negedge clk);
        check_val("abort_cyc_before", 32'(bus_if.cyc_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b1;
        req_i   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        rdata_exp = 32'd0;
        check_val("abort_cyc", 32'(bus_if.cyc_o), 32'd0);
        check_val("abort_stb", 32'(bus_if.stb_o), 32'd0);
        check_val("abort_adr", 32'(bus_if.adr_o), 32'd0);
        check_val("abort_rdata", rdata_o, 32'd0);
        check_val("abort_stall", 32'(stall_o), 32'd0);
        bus_if.ack_i = 1'b1;
        bus_if.dat_i = 32'h1234_5678;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus_if.ack_i = 1'b0;
        check_val("late_ack_rdata", rdata_o, rdata_exp);
        check_val("late_ack_cyc", 32'(bus_if.cyc_o), 32'd0);
        req_i = 1'b1;
        #1;
        check_val("post_rst_stall", 32'(stall_o), 32'd1);
        req_i = 1'b0;
        #1;
        check_val("post_rst_nostall", 32'(stall_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_bus_adapter.md
DMEM_BUS_ADAPTER -- requirements
Module: dmem_bus_adapter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8'd255, giving the bus cycles allowed before an access is aborted.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_i, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port req_i, input, 1, the core load/store request valid (EX stage).
REQ-005 SHALL have port we_i, input, 1, 1 = store, 0 = load.
REQ-006 SHALL have port addr_i, input, 32, the word-aligned access address from the load/store unit.
REQ-007 SHALL have port wdata_i, input, 32, the lane-shifted store data.
REQ-008 SHALL have port wmask_i, input, 4, the store byte-lane mask.
REQ-009 SHALL have port rdata_o, output, 32, the registered read word for MEM-stage extraction.
REQ-010 SHALL have port stall_o, output, 1, the pipeline hold request.
REQ-011 SHALL have port err_o, output, 1, a one-cycle access fault pulse.
REQ-012 SHALL have bus ports cyc_o, stb_o and we_o, each output, 1.
REQ-013 SHALL have bus ports adr_o, output, 30 (word address), dat_o, output, 32, and sel_o, output, 4.
REQ-014 SHALL have bus ports dat_i, input, 32, ack_i, input, 1, and err_i, input, 1.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, BUS and DONE.
REQ-016 IDLE: stall_o SHALL equal req_i combinationally.
REQ-017 IDLE with req_i=1: the block SHALL latch addr_i[31:2], wdata_i, wmask_i and we_i, then enter BUS.
REQ-018 BUS: cyc_o, stb_o and stall_o SHALL be 1, and adr_o, dat_o and we_o SHALL drive the latched values.
REQ-019 BUS: sel_o SHALL be the latched mask for a store and 4'b1111 for a load.
REQ-020 BUS with ack_i=1 and err_i=0: the block SHALL enter DONE, and on a load SHALL capture dat_i into rdata_o on that edge.
REQ-021 BUS with err_i=1: the block SHALL enter DONE with err_o=1 in DONE and rdata_o=0, and SHALL ignore any simultaneous ack_i.
REQ-022 The timeout counter SHALL clear on entry to BUS and increment each BUS cycle without ack/err.
REQ-023 When the counter reaches TIMEOUT_CYCLES, the block SHALL be treated as err_i=1 on that cycle.
REQ-024 DONE: cyc_o, stb_o and stall_o SHALL be 0, and the FSM SHALL return to IDLE unconditionally.
REQ-025 DONE: req_i SHALL be ignored; the next request is sampled in IDLE.
REQ-026 Minimum access latency SHALL be 3 cycles: IDLE, BUS (ack in the first BUS cycle), DONE.
REQ-027 rdata_o SHALL hold its value until the next successful load capture; stores SHALL NOT modify rdata_o.
REQ-028 ack_i and err_i SHALL be ignored outside BUS.
REQ-029 Misaligned accesses arrive as two consecutive requests and SHALL be served as two independent transactions, with no merging.
REQ-030 err_o SHALL be high only in DONE following an error or timeout.

Reset
REQ-031 With reset_i=1 at a rising edge, state SHALL become IDLE, and cyc_o, stb_o, we_o, err_o and the counter SHALL become 0.
REQ-032 With reset_i=1 at a rising edge, rdata_o, adr_o, dat_o and the latched mask SHALL become 0.
REQ-033 Reset asserted during BUS SHALL drop cyc_o/stb_o after that edge, and any later ack_i for the aborted access SHALL be ignored.
REQ-034 stall_o SHALL still follow req_i combinationally when the FSM is in IDLE after reset.

Verification
REQ-035 Load, zero-wait: req_i=1, we_i=0, addr_i=0x0000_1004, ack_i in the first BUS cycle with dat_i=0xDEADBEEF -> adr_o=0x401, sel_o=4'hF, stall_o high 2 cycles, then rdata_o=0xDEADBEEF.
REQ-036 Store, 3 waits: addr_i=0x20, wdata_i=0x0000AB00, wmask_i=4'b0010 -> we_o=1, sel_o=4'b0010, dat_o=0x0000AB00, and cyc_o held 4 cycles until ack_i.
REQ-037 Error with simultaneous ack: ack_i=1 and err_i=1 together on a load -> err_o one-cycle pulse in DONE, rdata_o=0.
REQ-038 Timeout: TIMEOUT_CYCLES=4 and no ack -> exactly 4 BUS cycles, then DONE with err_o=1, and a late ack_i is ignored.
REQ-039 Misaligned pair: two back-to-back requests to 0x100 and 0x104 -> two separate bus cycles, each with its own DONE, and stall_o low only in each DONE.
REQ-040 Reset mid-BUS: reset_i pulsed during a wait -> cyc_o=0 next cycle, state IDLE, and a subsequent ack_i produces no rdata_o change.
